// File: rtl/ysyx_22040237_mcyc_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and write-back
// handshakes with a per-wait-state watchdog and retired/busy cycle counters.
module ysyx_22040237_mcyc_ctrl #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        if_req_valid,
  input  logic        if_req_ready,
  input  logic        if_rsp_valid,
  input  logic        dec_is_mem,
  input  logic        dec_is_multi,
  input  logic        dec_ebreak,
  input  logic        dec_invalid,
  output logic        exu_start,
  input  logic        exu_done,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic        wb_en,
  output logic        pc_update,
  output logic        busy,
  output logic        halted,
  output logic [1:0]  halt_code,
  output logic [63:0] inst_cnt,
  output logic [63:0] cycle_cnt
);

  localparam int unsigned WDW = $clog2(TIMEOUT) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MREQ, S_MWAIT, S_WB, S_HALT
  } state_t;

  state_t         state, next;
  logic [WDW-1:0] wd;
  logic           is_mem_q, is_multi_q;
  logic           waiting, exit_ok, wd_expired;
  logic [1:0]     next_code;

  assign wd_expired    = (wd == WDW'(TIMEOUT - 1));
  assign if_req_valid  = (state == S_FETCH);
  assign lsu_req_valid = (state == S_MREQ);
  assign busy          = (state != S_IDLE) && (state != S_HALT);
  assign halted        = (state == S_HALT);

  always_comb begin
    next      = state;
    waiting   = 1'b0;
    exit_ok   = 1'b0;
    next_code = halt_code;
    case (state)
      S_IDLE:   if (start) next = S_FETCH;
      S_FETCH: begin
        waiting = 1'b1;
        exit_ok = if_req_ready;
        if (if_req_ready) next = if_rsp_valid ? S_DECODE : S_FWAIT;
      end
      S_FWAIT: begin
        waiting = 1'b1;
        exit_ok = if_rsp_valid;
        if (if_rsp_valid) next = S_DECODE;
      end
      S_DECODE: begin
        if (dec_invalid) begin
          next      = S_HALT;
          next_code = 2'd2;
        end else if (dec_ebreak) begin
          next      = S_HALT;
          next_code = 2'd1;
        end else begin
          next = S_EXEC;
        end
      end
      S_EXEC: begin
        waiting = 1'b1;
        exit_ok = !is_multi_q || exu_done;
        if (exit_ok) next = is_mem_q ? S_MREQ : S_WB;
      end
      S_MREQ: begin
        waiting = 1'b1;
        exit_ok = lsu_req_ready;
        if (lsu_req_ready) next = lsu_rsp_valid ? S_WB : S_MWAIT;
      end
      S_MWAIT: begin
        waiting = 1'b1;
        exit_ok = lsu_rsp_valid;
        if (lsu_rsp_valid) next = S_WB;
      end
      S_WB:     next = S_FETCH;
      S_HALT:   next = S_HALT;
      default:  next = S_IDLE;
    endcase
    // A wait that is satisfied on its last allowed cycle still proceeds normally
    if (waiting && !exit_ok && wd_expired) begin
      next      = S_HALT;
      next_code = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      wd         <= '0;
      is_mem_q   <= 1'b0;
      is_multi_q <= 1'b0;
      exu_start  <= 1'b0;
      wb_en      <= 1'b0;
      pc_update  <= 1'b0;
      halt_code  <= '0;
      inst_cnt   <= '0;
      cycle_cnt  <= '0;
    end else begin
      state      <= next;
      wd         <= (next != state || !waiting) ? '0 : wd + WDW'(1);
      if (state == S_DECODE) begin
        is_mem_q   <= dec_is_mem;
        is_multi_q <= dec_is_multi;
      end
      exu_start  <= (state == S_DECODE) && (next == S_EXEC);
      wb_en      <= (next == S_WB);
      pc_update  <= (next == S_WB);
      halt_code  <= next_code;
      if (state == S_WB) inst_cnt <= inst_cnt + 64'd1;
      if (busy) cycle_cnt <= cycle_cnt + 64'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_mcyc_ctrl.sv
// Directed bench for ysyx_22040237_mcyc_ctrl: table of single-instruction timing
// vectors with a reactive handshake responder, plus halt/timeout/reset sequences.
module tb_ysyx_22040237_mcyc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        if_req_valid, if_req_ready = 1'b0, if_rsp_valid = 1'b0;
  logic        dec_is_mem = 1'b0, dec_is_multi = 1'b0, dec_ebreak = 1'b0, dec_invalid = 1'b0;
  logic        exu_start, exu_done = 1'b0;
  logic        lsu_req_valid, lsu_req_ready = 1'b0, lsu_rsp_valid = 1'b0;
  logic        wb_en, pc_update, busy, halted;
  logic [1:0]  halt_code;
  logic [63:0] inst_cnt, cycle_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22040237_mcyc_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_rsp_valid(if_rsp_valid),
    .dec_is_mem(dec_is_mem), .dec_is_multi(dec_is_multi),
    .dec_ebreak(dec_ebreak), .dec_invalid(dec_invalid),
    .exu_start(exu_start), .exu_done(exu_done),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .wb_en(wb_en), .pc_update(pc_update), .busy(busy), .halted(halted),
    .halt_code(halt_code), .inst_cnt(inst_cnt), .cycle_cnt(cycle_cnt)
  );

  typedef struct {
    int req_d;   // cycles if_req_valid waits before ready
    int rsp_d;   // cycles after fetch accept until rsp (0 = same cycle)
    bit multi;
    int exu_d;   // EXEC cycles before exu_done (0 = first cycle)
    bit mem;
    int lreq_d;
    int lrsp_d;
    int exp_lat; // cycle index of wb_en counted from first FETCH cycle
    int exp_lsu; // cycles lsu_req_valid is high
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    start = 0; if_req_ready = 0; if_rsp_valid = 0;
    dec_is_mem = 0; dec_is_multi = 0; dec_ebreak = 0; dec_invalid = 0;
    exu_done = 0; lsu_req_ready = 0; lsu_rsp_valid = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 0;
    clear_inputs();
    #1;
    check({tag, "_outs_zero"},
          {57'd0, if_req_valid, exu_start, lsu_req_valid, wb_en, pc_update, busy, halted}, 64'd0);
    check({tag, "_code_zero"}, {62'd0, halt_code}, 64'd0);
    check({tag, "_cnts_zero"}, inst_cnt | cycle_cnt, 64'd0);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic run_instr(input vec_t v, output int lat, output int lsu_n, output int exu_n,
                           output int pc_n, output logic [63:0] inst_wb);
    int  c = 0, f_seen = 0, f_k = 0, ex_k = 0, l_seen = 0, l_k = 0;
    bit  f_acc = 0, in_exec = 0, l_acc = 0;
    lat = -1; lsu_n = 0; exu_n = 0; pc_n = 0; inst_wb = '1;
    while (c < 200) begin
      @(negedge clk);
      c++;
      start = 0;
      dec_is_mem = v.mem; dec_is_multi = v.multi; dec_ebreak = 0; dec_invalid = 0;
      if (exu_start) begin exu_n++; in_exec = 1; ex_k = 0; end
      else if (in_exec) ex_k++;
      if (lsu_req_valid) lsu_n++;
      if (pc_update) pc_n++;
      if (wb_en) begin lat = c; inst_wb = inst_cnt; break; end
      if (f_acc) f_k++;
      if_req_ready = if_req_valid && (f_seen >= v.req_d);
      if (if_req_valid) f_seen++;
      if_rsp_valid = (if_req_ready && v.rsp_d == 0) || (f_acc && f_k == v.rsp_d);
      if (if_req_ready) f_acc = 1;
      exu_done = v.multi && in_exec && (ex_k >= v.exu_d);
      if (l_acc) l_k++;
      lsu_req_ready = lsu_req_valid && (l_seen >= v.lreq_d);
      if (lsu_req_valid) l_seen++;
      lsu_rsp_valid = (lsu_req_ready && v.lrsp_d == 0) || (l_acc && l_k == v.lrsp_d);
      if (lsu_req_ready) l_acc = 1;
    end
  endtask

  task automatic halt_test(input string tag, input logic eb, input logic inv, input logic [1:0] code);
    int hc = -1, wbn = 0, exn = 0;
    do_reset(tag);
    @(negedge clk);
    start = 1; if_req_ready = 1; if_rsp_valid = 1; dec_ebreak = eb; dec_invalid = inv;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 0;
      if (wb_en || pc_update) wbn++;
      if (exu_start) exn++;
      if (halted) begin hc = c; break; end
    end
    check({tag, "_halt_cycle"}, 64'(hc), 64'd3);
    check({tag, "_code"}, {62'd0, halt_code}, {62'd0, code});
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_no_wb_exu"}, 64'(wbn + exn), 64'd0);
    check({tag, "_cycle_cnt"}, cycle_cnt, 64'd2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = i[0]; exu_done = 1; lsu_req_ready = 1; lsu_rsp_valid = 1;
      dec_ebreak = 0; dec_invalid = 0;
      if (wb_en || pc_update) wbn++;
    end
    @(negedge clk);
    check({tag, "_still_halted"}, {62'd0, halted, if_req_valid}, 64'd2);
    check({tag, "_code_held"}, {62'd0, halt_code}, {62'd0, code});
    check({tag, "_frozen_cnts"}, inst_cnt + cycle_cnt + 64'(wbn), 64'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, lsu_n, exu_n, pc_n, cum, sum_lat, k, hk, wbn;
    logic [63:0] inst_wb, exp_inst;

    //           req rsp mul exu mem lrq lrs lat lsu
    vecs[0] = '{0,  0,  0,  0,  0,  0,  0,  4,  0};
    vecs[1] = '{2,  0,  0,  0,  0,  0,  0,  6,  0};
    vecs[2] = '{0,  3,  0,  0,  0,  0,  0,  7,  0};
    vecs[3] = '{0,  0,  1,  0,  0,  0,  0,  4,  0};
    vecs[4] = '{0,  0,  1,  5,  0,  0,  0,  9,  0};
    vecs[5] = '{0,  0,  0,  0,  1,  2,  3, 10,  3};
    vecs[6] = '{0,  0,  0,  0,  1,  0,  0,  5,  1};
    vecs[7] = '{1,  2,  1,  3,  1,  1,  1, 13,  2};
    vecs[8] = '{0,  0,  1, 15,  0,  0,  0, 19,  0};
    vecs[9] = '{0,  0,  0,  0,  1, 15,  0, 20, 16};

    clear_inputs();
    #3;
    check("por_outs_zero",
          {57'd0, if_req_valid, exu_start, lsu_req_valid, wb_en, pc_update, busy, halted}, 64'd0);
    check("por_cnts_zero", inst_cnt | cycle_cnt | {62'd0, halt_code}, 64'd0);
    @(negedge clk);
    rst = 1;

    // Three back-to-back ALU instructions with zero-wait fetch
    @(negedge clk);
    start = 1;
    cum = 0;
    for (int i = 0; i < 3; i++) begin
      run_instr(vecs[0], lat, lsu_n, exu_n, pc_n, inst_wb);
      cum += lat;
      check($sformatf("alu%0d_wb_cycle", i), 64'(cum), 64'(4 * (i + 1)));
    end
    @(negedge clk);
    check("alu3_inst_cnt", inst_cnt, 64'd3);
    check("alu3_cycle_cnt", cycle_cnt, 64'd12);

    // Table of timing vectors, executed back-to-back from a fresh reset
    do_reset("tbl");
    @(negedge clk);
    start = 1;
    exp_inst = 0;
    sum_lat = 0;
    for (int i = 0; i < 10; i++) begin
      run_instr(vecs[i], lat, lsu_n, exu_n, pc_n, inst_wb);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_lsu_cycles", i), 64'(lsu_n), 64'(vecs[i].exp_lsu));
      check($sformatf("v%0d_exu_start", i), 64'(exu_n), 64'd1);
      check($sformatf("v%0d_pc_update", i), 64'(pc_n), 64'd1);
      check($sformatf("v%0d_inst_cnt", i), inst_wb, exp_inst);
      exp_inst++;
      sum_lat += vecs[i].exp_lat;
    end
    check("tbl_cycle_cnt", cycle_cnt, 64'(sum_lat - 1));

    halt_test("ebreak", 1'b1, 1'b0, 2'd1);
    halt_test("inv_ebreak", 1'b1, 1'b1, 2'd2);

    // Multi-cycle execute that never completes: watchdog after 16 EXEC cycles
    do_reset("wdog");
    @(negedge clk);
    start = 1; if_req_ready = 1; if_rsp_valid = 1; dec_is_multi = 1; exu_done = 0;
    k = 0; hk = -1; wbn = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      start = 0;
      if (wb_en || pc_update) wbn++;
      if (exu_start) k = 1;
      else if (k > 0) k++;
      if (halted) begin hk = k; break; end
    end
    check("wdog_halt_cycle", 64'(hk), 64'd17);
    check("wdog_code", {62'd0, halt_code}, 64'd3);
    check("wdog_no_wb", 64'(wbn), 64'd0);

    // Reset while waiting for a memory response
    do_reset("pre_mwait");
    @(negedge clk);
    start = 1; if_req_ready = 1; if_rsp_valid = 1; dec_is_mem = 1; lsu_req_ready = 1;
    wbn = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 0;
      if (wb_en || pc_update) wbn++;
      if (c == 4) check("mwait_mreq_seen", {63'd0, lsu_req_valid}, 64'd1);
    end
    check("mwait_state", {62'd0, busy, lsu_req_valid}, 64'd2);
    do_reset("in_mwait");
    lsu_rsp_valid = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wb_en || pc_update || busy) wbn++;
    end
    check("mwait_no_wb", 64'(wbn), 64'd0);
    lsu_rsp_valid = 0;
    start = 1;
    run_instr(vecs[0], lat, lsu_n, exu_n, pc_n, inst_wb);
    check("post_rst_latency", 64'(lat), 64'd4);
    check("post_rst_inst_cnt", inst_wb, 64'd0);
    @(negedge clk);
    check("post_rst_inst_one", inst_cnt, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040237_mcyc_ctrl.md
YSYX_22040237_MCYC_CTRL -- requirements
Module: ysyx_22040237_mcyc_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: maximum cycles in any single wait state before a watchdog abort.
REQ-002 SHALL have ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that starts execution from IDLE.
- if_req_valid  output  1  fetch request.
- if_req_ready  input  1  fetch request accepted.
- if_rsp_valid  input  1  instruction word valid.
- dec_is_mem  input  1  decoded instruction is a load or store; sampled in DECODE.
- dec_is_multi  input  1  decoded instruction needs a multi-cycle execute; sampled in DECODE.
- dec_ebreak  input  1  decoded instruction is ebreak; sampled in DECODE.
- dec_invalid  input  1  decoded instruction is invalid; sampled in DECODE.
- exu_start  output  1  one-cycle execute-unit start pulse.
- exu_done  input  1  multi-cycle execute result ready.
- lsu_req_valid  output  1  memory request.
- lsu_req_ready  input  1  memory request accepted.
- lsu_rsp_valid  input  1  memory response valid.
- wb_en  output  1  one-cycle register-file write-back pulse.
- pc_update  output  1  one-cycle pulse; PC takes the next or jump address.
- busy  output  1  state is neither IDLE nor HALT.
- halted  output  1  state is HALT.
- halt_code  output  2  halt cause: 0 none, 1 ebreak, 2 invalid instruction, 3 watchdog.
- inst_cnt  output  64  count of retired instructions.
- cycle_cnt  output  64  count of cycles while busy.

Function
REQ-003 SHALL implement the states IDLE, FETCH, FWAIT, DECODE, EXEC, MREQ, MWAIT, WB and HALT, all of them registered.
REQ-004 IDLE: SHALL move to FETCH when start=1; otherwise stays in IDLE.
REQ-005 FETCH: SHALL drive if_req_valid=1, and stays until if_req_ready=1, then moves to FWAIT.
- If if_rsp_valid=1 in the same cycle as if_req_ready=1, SHALL go directly to DECODE.
REQ-006 FWAIT: SHALL move to DECODE when if_rsp_valid=1.
REQ-007 DECODE (exactly 1 cycle) SHALL leave by the first matching rule, in this priority order:
- dec_invalid -> HALT with code 2.
- dec_ebreak -> HALT with code 1.
- Otherwise -> EXEC, pulsing exu_start=1 for that one transition cycle.
- Invalid and ebreak instructions SHALL NOT pulse wb_en or pc_update.
REQ-008 EXEC, not multi-cycle: SHALL leave after 1 cycle.
REQ-009 EXEC, multi-cycle: SHALL wait for exu_done=1, including exu_done=1 in the first EXEC cycle.
REQ-010 On leaving EXEC, SHALL go to MREQ if the latched dec_is_mem=1, else to WB.
REQ-011 MREQ: SHALL drive lsu_req_valid=1 until lsu_req_ready=1, then move to MWAIT.
- If lsu_rsp_valid=1 in the same cycle as lsu_req_ready=1, SHALL go directly to WB.
REQ-012 MWAIT: SHALL move to WB when lsu_rsp_valid=1.
REQ-013 WB (exactly 1 cycle): SHALL pulse wb_en=1 and pc_update=1, increment inst_cnt (wrapping modulo 2^64), and move to FETCH.
REQ-014 HALT: SHALL be absorbing; only reset leaves it.
- start and all handshake inputs SHALL be ignored in HALT.
- halt_code SHALL hold its value in HALT.
REQ-015 Watchdog counter:
- Cleared on every state transition.
- Increments each cycle spent in FETCH, FWAIT, EXEC, MREQ or MWAIT.
- When it reaches TIMEOUT-1 with the exit condition still false, the next state SHALL be HALT with code 3.
- An exit condition true in that same cycle SHALL take precedence over the timeout.
REQ-016 Output pulses:
- exu_start, wb_en and pc_update SHALL be registered outputs.
- Each SHALL be high for exactly one cycle per instruction.
- if_req_valid and lsu_req_valid SHALL be Moore outputs decoded from the state.
REQ-017 cycle_cnt SHALL increment every cycle that busy=1 and SHALL wrap modulo 2^64.
REQ-018 start asserted outside IDLE SHALL have no effect.
REQ-019 Minimum per-instruction latency (single-cycle execute, no memory access, zero-wait handshakes) SHALL be 4 cycles: FETCH, DECODE, EXEC, WB.

Reset
REQ-020 While rst=0, asynchronously:
- state SHALL be IDLE.
- All outputs SHALL be 0, with halt_code=0 and both counters 0.
- The watchdog counter SHALL be 0.
REQ-021 Reset asserted mid-instruction SHALL abandon the instruction with no wb_en or pc_update pulse; after rst=1 the block waits in IDLE for start.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then start; 3 ALU instructions with if_req_ready and if_rsp_valid tied to 1 -> wb_en pulses at cycles 4, 8 and 12 after start; inst_cnt=3.
- Load with lsu_req_ready delayed 2 cycles and lsu_rsp_valid 3 cycles later -> lsu_req_valid high 3 cycles; exactly one wb_en after the response; inst_cnt+1.
- dec_ebreak=1 at DECODE -> HALT, halt_code=1, halted=1, no wb_en; later start pulses ignored.
- dec_invalid=1 and dec_ebreak=1 together -> halt_code=2.
- Multi-cycle execute with exu_done held at 0 and TIMEOUT=16 -> HALT with halt_code=3 exactly 16 cycles after EXEC entry; exu_done=1 on cycle 16 instead -> normal WB.
- rst=0 asserted while in MWAIT -> all outputs 0 immediately; no wb_en; after rst=1 and start, inst_cnt restarts from 0.
